// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit: branch control encoding, FSM states,
// and 2-bit saturating counter helpers.
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_ALU  = 2'b01,
    BR_MEM  = 2'b10,
    BR_RSVD = 2'b11
  } br_ctrl_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } bru_state_t;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t CTR_RESET = 2'b01;
  localparam bht_ctr_t CTR_MAX   = 2'b11;
  localparam bht_ctr_t CTR_MIN   = 2'b00;

  function automatic bht_ctr_t ctr_inc(input bht_ctr_t c);
    return (c == CTR_MAX) ? c : c + 2'd1;
  endfunction

  function automatic bht_ctr_t ctr_dec(input bht_ctr_t c);
    return (c == CTR_MIN) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_bht.sv
// Direct-mapped branch history/target table: two combinational lookup ports
// (fetch and resolve) and one synchronous write port, cleared on reset.
module branch_history_table
  import branch_resolve_unit_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int IDX_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rd_pc_a_i,
  output logic             hit_a_o,
  output bht_ctr_t         ctr_a_o,
  output logic [WIDTH-1:0] tgt_a_o,
  input  logic [WIDTH-1:0] rd_pc_b_i,
  output logic             hit_b_o,
  output bht_ctr_t         ctr_b_o,
  output logic [WIDTH-1:0] tgt_b_o,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_pc_i,
  input  logic [WIDTH-1:0] wr_tgt_i,
  input  bht_ctr_t         wr_ctr_i
);

  localparam int TAG_W   = WIDTH - IDX_BITS - 1;
  localparam int ENTRIES = 1 << IDX_BITS;

  logic             valid_q [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [WIDTH-1:0] tgt_q   [ENTRIES];
  bht_ctr_t         ctr_q   [ENTRIES];

  logic [IDX_BITS-1:0] idx_a, idx_b, idx_w;
  logic [TAG_W-1:0]    tag_a, tag_b, tag_w;

  // Bit 0 of a PC is always zero for word-aligned fetches.
  assign idx_a = rd_pc_a_i[IDX_BITS:1];
  assign idx_b = rd_pc_b_i[IDX_BITS:1];
  assign idx_w = wr_pc_i[IDX_BITS:1];
  assign tag_a = rd_pc_a_i[WIDTH-1:IDX_BITS+1];
  assign tag_b = rd_pc_b_i[WIDTH-1:IDX_BITS+1];
  assign tag_w = wr_pc_i[WIDTH-1:IDX_BITS+1];

  logic unused_pc_lsb;
  assign unused_pc_lsb = rd_pc_a_i[0] ^ rd_pc_b_i[0] ^ wr_pc_i[0];

  assign hit_a_o = valid_q[idx_a] && (tag_q[idx_a] == tag_a);
  assign ctr_a_o = ctr_q[idx_a];
  assign tgt_a_o = tgt_q[idx_a];
  assign hit_b_o = valid_q[idx_b] && (tag_q[idx_b] == tag_b);
  assign ctr_b_o = ctr_q[idx_b];
  assign tgt_b_o = tgt_q[idx_b];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_RESET;
      end
    end else if (wr_en_i) begin
      valid_q[idx_w] <= 1'b1;
      tag_q[idx_w]   <= tag_w;
      tgt_q[idx_w]   <= wr_tgt_i;
      ctr_q[idx_w]   <= wr_ctr_i;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Fetch-side prediction plus WB-stage branch resolution with a registered
// flush/redirect sequence. Optional counters enabled by `define BRANCH_STATS_EN.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int IDX_BITS     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] fetch_pc,
  output logic [WIDTH-1:0] predict_addr,
  output logic             predict_taken,
  input  logic             resolve_valid,
  input  logic             resolve_isbranch,
  input  logic [WIDTH-1:0] resolve_pc,
  input  logic [1:0]       br_ctrl,
  input  logic [WIDTH-1:0] alu_target,
  input  logic [WIDTH-1:0] mem_target,
  input  logic [WIDTH-1:0] resolve_predict_addr,
`ifdef BRANCH_STATS_EN
  output logic [31:0]      branch_count,
  output logic [31:0]      mispredict_count,
`endif
  output logic             flush,
  output logic [WIDTH-1:0] redirect_pc
);

  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  bru_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] redir_q, redir_d;

  br_ctrl_t         br;
  logic [WIDTH-1:0] sel, actual_next;
  logic             sel_vld, check_en, mispredict, taken;

  logic             hit_a, hit_b;
  bht_ctr_t         ctr_a, ctr_b, wr_ctr;
  logic [WIDTH-1:0] tgt_a, tgt_b, wr_tgt;
  logic             wr_en;

  branch_history_table #(.WIDTH(WIDTH), .IDX_BITS(IDX_BITS)) u_bht (
    .clk       (clk),
    .reset     (reset),
    .rd_pc_a_i (fetch_pc),
    .hit_a_o   (hit_a),
    .ctr_a_o   (ctr_a),
    .tgt_a_o   (tgt_a),
    .rd_pc_b_i (resolve_pc),
    .hit_b_o   (hit_b),
    .ctr_b_o   (ctr_b),
    .tgt_b_o   (tgt_b),
    .wr_en_i   (wr_en),
    .wr_pc_i   (resolve_pc),
    .wr_tgt_i  (wr_tgt),
    .wr_ctr_i  (wr_ctr)
  );

  logic unused_ctr_lsb;
  assign unused_ctr_lsb = ctr_a[0];

  assign predict_taken = hit_a & ctr_a[1];
  assign predict_addr  = predict_taken ? tgt_a : fetch_pc + WIDTH'(2);

  assign br = br_ctrl_t'(br_ctrl);

  always_comb begin
    sel     = resolve_pc;
    sel_vld = 1'b0;
    unique case (br)
      BR_ALU:  begin sel = alu_target; sel_vld = 1'b1; end
      BR_MEM:  begin sel = mem_target; sel_vld = 1'b1; end
      BR_NONE: begin sel = resolve_pc; sel_vld = resolve_isbranch; end
      default: begin sel = resolve_pc; sel_vld = 1'b0; end
    endcase
  end

  assign actual_next = sel + WIDTH'(2);
  assign check_en    = resolve_valid & (state_q == IDLE) & sel_vld;
  assign mispredict  = check_en & (actual_next != resolve_predict_addr);
  assign taken       = (br != BR_NONE);

  // Not-taken only trains an entry this branch already owns; jumps pin strongly taken.
  always_comb begin
    wr_en  = check_en & (taken | hit_b);
    wr_tgt = taken ? sel : tgt_b;
    if (!resolve_isbranch) wr_ctr = CTR_MAX;
    else if (taken)        wr_ctr = ctr_inc(ctr_b);
    else                   wr_ctr = ctr_dec(ctr_b);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      redir_q <= redir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    redir_d = redir_q;
    unique case (state_q)
      IDLE: if (mispredict) begin
        state_d = FLUSH;
        cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        redir_d = actual_next;
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush       = (state_q == FLUSH);
    redirect_pc = redir_q;
  end

`ifdef BRANCH_STATS_EN
  logic [31:0] br_cnt_q, mp_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      if (check_en && br_cnt_q != 32'hFFFF_FFFF)   br_cnt_q <= br_cnt_q + 32'd1;
      if (mispredict && mp_cnt_q != 32'hFFFF_FFFF) mp_cnt_q <= mp_cnt_q + 32'd1;
    end
  end

  assign branch_count     = br_cnt_q;
  assign mispredict_count = mp_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; stats checks active when BRANCH_STATS_EN is defined.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fetch_pc;
  logic [15:0] predict_addr;
  logic        predict_taken;
  logic        resolve_valid;
  logic        resolve_isbranch;
  logic [15:0] resolve_pc;
  logic [1:0]  br_ctrl;
  logic [15:0] alu_target;
  logic [15:0] mem_target;
  logic [15:0] resolve_predict_addr;
  logic        flush;
  logic [15:0] redirect_pc;
`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk                  (clk),
    .reset                (reset),
    .fetch_pc             (fetch_pc),
    .predict_addr         (predict_addr),
    .predict_taken        (predict_taken),
    .resolve_valid        (resolve_valid),
    .resolve_isbranch     (resolve_isbranch),
    .resolve_pc           (resolve_pc),
    .br_ctrl              (br_ctrl),
    .alu_target           (alu_target),
    .mem_target           (mem_target),
    .resolve_predict_addr (resolve_predict_addr),
`ifdef BRANCH_STATS_EN
    .branch_count         (branch_count),
    .mispredict_count     (mispredict_count),
`endif
    .flush                (flush),
    .redirect_pc          (redirect_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic resolve(input logic isb, input logic [1:0] br, input logic [15:0] pc,
                         input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] pred);
    resolve_valid        = 1'b1;
    resolve_isbranch     = isb;
    br_ctrl              = br;
    resolve_pc           = pc;
    alu_target           = alu;
    mem_target           = mem;
    resolve_predict_addr = pred;
    #1;
  endtask

  task automatic resolve_once(input logic isb, input logic [1:0] br, input logic [15:0] pc,
                              input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] pred);
    resolve(isb, br, pc, alu, mem, pred);
    step();
    resolve_valid = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; fetch_pc = 16'h3000; resolve_valid = 1'b0; resolve_isbranch = 1'b0;
    resolve_pc = '0; br_ctrl = 2'b00; alu_target = '0; mem_target = '0; resolve_predict_addr = '0;
    step(); step();
    reset = 1'b0;
    step();

    chk("rst_flush",    {31'b0, flush},         32'h0);
    chk("rst_redirect", {16'b0, redirect_pc},   32'h0);
    chk("rst_paddr",    {16'b0, predict_addr},  32'h3002);
    chk("rst_ptaken",   {31'b0, predict_taken}, 32'h0);

    // Taken ALU branch mispredicted as fall-through; same-cycle lookup sees old entry
    resolve(1'b1, 2'b01, 16'h3000, 16'h3040, 16'h0, 16'h3002);
    chk("no_bypass", {16'b0, predict_addr}, 32'h3002);
    step(); resolve_valid = 1'b0; #1;
    chk("mp1_flush",  {31'b0, flush},         32'h1);
    chk("mp1_redir",  {16'b0, redirect_pc},   32'h3042);
    chk("mp1_paddr",  {16'b0, predict_addr},  32'h3040);
    chk("mp1_ptaken", {31'b0, predict_taken}, 32'h1);
    step();
    chk("mp1_flush_c2", {31'b0, flush}, 32'h1);
    step();
    chk("mp1_flush_end", {31'b0, flush}, 32'h0);

    // Correct MEM predictions: ctr 10->11, then saturates at 11
    resolve_once(1'b1, 2'b10, 16'h3000, 16'h0, 16'h4000, 16'h4002);
    chk("ok1_flush", {31'b0, flush},        32'h0);
    chk("ok1_paddr", {16'b0, predict_addr}, 32'h4000);
    resolve_once(1'b1, 2'b10, 16'h3000, 16'h0, 16'h4000, 16'h4002);
    chk("ok2_flush", {31'b0, flush}, 32'h0);

    // Not-taken resolves: 11->10 (still taken), 10->01, 01->00, 00 stays
    resolve_once(1'b1, 2'b00, 16'h3000, 16'h0, 16'h0, 16'h4000);
    chk("nt1_flush",  {31'b0, flush},         32'h1);
    chk("nt1_redir",  {16'b0, redirect_pc},   32'h3002);
    chk("nt1_ptaken", {31'b0, predict_taken}, 32'h1);
    step(); step();
    chk("nt1_idle", {31'b0, flush}, 32'h0);
    resolve_once(1'b1, 2'b00, 16'h3000, 16'h0, 16'h0, 16'h4000);
    chk("nt2_flush",  {31'b0, flush},         32'h1);
    chk("nt2_ptaken", {31'b0, predict_taken}, 32'h0);
    chk("nt2_paddr",  {16'b0, predict_addr},  32'h3002);
    step(); step();
    resolve_once(1'b1, 2'b00, 16'h3000, 16'h0, 16'h0, 16'h3002);
    chk("nt3_flush", {31'b0, flush}, 32'h0);
    resolve_once(1'b1, 2'b00, 16'h3000, 16'h0, 16'h0, 16'h3002);
    chk("nt4_flush", {31'b0, flush}, 32'h0);

    // From 00 one taken resolve gives 01: still predicted not-taken
    resolve_once(1'b1, 2'b01, 16'h3000, 16'h3040, 16'h0, 16'h3002);
    chk("uf_flush",  {31'b0, flush},         32'h1);
    chk("uf_ptaken", {31'b0, predict_taken}, 32'h0);

    // Wrong-path mispredicts during FLUSH, including its last cycle, are ignored
    resolve(1'b1, 2'b01, 16'h3010, 16'h5000, 16'h0, 16'h3012);
    step();
    chk("wp_flush_last", {31'b0, flush}, 32'h1);
    step();
    resolve_valid = 1'b0; #1;
    chk("wp_exit", {31'b0, flush}, 32'h0);
    step();
    chk("wp_no_retrig", {31'b0, flush},       32'h0);
    chk("wp_redir",     {16'b0, redirect_pc}, 32'h3042);
    fetch_pc = 16'h3010; #1;
    chk("wp_no_update", {16'b0, predict_addr},  32'h3012);
    chk("wp_no_taken",  {31'b0, predict_taken}, 32'h0);
    fetch_pc = 16'h3000;

    // Reset during FLUSH aborts it and clears the table
    resolve_once(1'b1, 2'b01, 16'h3000, 16'h3040, 16'h0, 16'h3002);
    chk("rmf_flush", {31'b0, flush}, 32'h1);
    reset = 1'b1;
    step();
    chk("rmf_abort", {31'b0, flush},       32'h0);
    chk("rmf_redir", {16'b0, redirect_pc}, 32'h0);
    reset = 1'b0;
    step();
    chk("rmf_cleared", {16'b0, predict_addr}, 32'h3002);
    chk("rmf_ptaken",  {31'b0, predict_taken}, 32'h0);

    // Address wrap: target 0xFFFE resolves to 0x0000
    fetch_pc = 16'h3020;
    resolve_once(1'b1, 2'b01, 16'h3020, 16'hFFFE, 16'h0, 16'h0000);
    chk("wrap_flush", {31'b0, flush},        32'h0);
    chk("wrap_paddr", {16'b0, predict_addr}, 32'hFFFE);
    resolve_once(1'b1, 2'b10, 16'h3020, 16'h0, 16'hFFFE, 16'h0000);
    chk("wrap_mem_flush", {31'b0, flush}, 32'h0);
    resolve_once(1'b1, 2'b01, 16'h3020, 16'hFFFE, 16'h0, 16'hFFFE);
    chk("wrap_mp_flush", {31'b0, flush},       32'h1);
    chk("wrap_mp_redir", {16'b0, redirect_pc}, 32'h0000);
    fetch_pc = 16'hFFFE; #1;
    chk("wrap_fetch", {16'b0, predict_addr}, 32'h0000);
`ifdef BRANCH_STATS_EN
    chk("stat_branches",    branch_count,     32'd3);
    chk("stat_mispredicts", mispredict_count, 32'd1);
`endif
    step(); step();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
